// File: rtl/sargantana_icache_pkg.sv
// Shared types for the instruction-cache tag controller.
package sargantana_icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    REFILL,
    WRITE,
    FLUSH
  } itag_state_e;

  // Wide enough for up to 16 ways; unused upper bits stay zero.
  localparam int WAY_IDX_W = 4;
  typedef logic [WAY_IDX_W-1:0] way_idx_t;

endpackage

// File: rtl/sargantana_itag_victim_sel.sv
// Victim way picker: lowest invalid way first, otherwise the round-robin way.
module sargantana_itag_victim_sel
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = 4
) (
  input  logic [ICACHE_N_WAY-1:0] vbit,
  input  way_idx_t                rr,
  output logic [ICACHE_N_WAY-1:0] victim,
  output logic                    use_rr
);

  // Scan downwards so the lowest invalid way is the one left standing.
  always_comb begin
    victim = '0;
    use_rr = 1'b1;
    for (int w = ICACHE_N_WAY-1; w >= 0; w--) begin
      if (!vbit[w]) begin
        victim    = '0;
        victim[w] = 1'b1;
        use_rr    = 1'b0;
      end
    end
    if (use_rr) begin
      for (int w = 0; w < ICACHE_N_WAY; w++)
        victim[w] = (way_idx_t'(w) == rr);
    end
  end

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Instruction-cache tag controller: lookup, miss refill, tag write-back, flush.
module sargantana_itag_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_DEPTH      = 64,
  parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT      = 20
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic                                   lookup_valid_i,
  output logic                                   lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]              lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]                   lookup_tag_i,
  output logic                                   resp_valid_o,
  output logic                                   resp_hit_o,
  output logic [ICACHE_N_WAY-1:0]                resp_way_o,
  output logic                                   refill_req_o,
  input  logic                                   refill_done_i,
  input  logic                                   flush_i,
  output logic [ICACHE_N_WAY-1:0]                tm_req_o,
  output logic                                   tm_we_o,
  output logic                                   tm_vbit_o,
  output logic                                   tm_flush_o,
  output logic [TAG_WIDHT-1:0]                   tm_data_o,
  output logic [TAG_ADDR_WIDHT-1:0]              tm_addr_o,
  input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tm_tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]                tm_vbit_i
);

  itag_state_e                 state_q, state_d;
  logic [TAG_ADDR_WIDHT-1:0]   idx_q;
  logic [TAG_WIDHT-1:0]        tag_q;
  logic [ICACHE_N_WAY-1:0]     victim_q, victim_d, hit_oh;
  logic                        use_rr_q, use_rr_d, any_hit;
  logic                        load_lookup, load_victim, bump_rr;
  way_idx_t                    rr_q;

  sargantana_itag_victim_sel #(.ICACHE_N_WAY(ICACHE_N_WAY)) u_victim (
    .vbit   (tm_vbit_i),
    .rr     (rr_q),
    .victim (victim_d),
    .use_rr (use_rr_d)
  );

  // Per-way tag match, reduced to the lowest matching way.
  always_comb begin
    hit_oh  = '0;
    any_hit = 1'b0;
    for (int w = ICACHE_N_WAY-1; w >= 0; w--) begin
      if (tm_vbit_i[w] && (tm_tag_way_i[w] == tag_q)) begin
        hit_oh    = '0;
        hit_oh[w] = 1'b1;
        any_hit   = 1'b1;
      end
    end
  end

  // Next state and all outputs; flush overrides everything, reset masks outputs.
  always_comb begin
    state_d        = state_q;
    lookup_ready_o = 1'b0;
    resp_valid_o   = 1'b0;
    resp_hit_o     = 1'b0;
    resp_way_o     = '0;
    refill_req_o   = 1'b0;
    tm_req_o       = '0;
    tm_we_o        = 1'b0;
    tm_vbit_o      = 1'b0;
    tm_flush_o     = 1'b0;
    tm_data_o      = '0;
    tm_addr_o      = '0;
    load_lookup    = 1'b0;
    load_victim    = 1'b0;
    bump_rr        = 1'b0;
    unique case (state_q)
      IDLE: begin
        lookup_ready_o = !flush_i;
        if (lookup_valid_i && !flush_i) begin
          tm_req_o    = '1;
          tm_addr_o   = lookup_idx_i;
          load_lookup = 1'b1;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (!flush_i) begin
          if (any_hit) begin
            resp_valid_o = 1'b1;
            resp_hit_o   = 1'b1;
            resp_way_o   = hit_oh;
            state_d      = IDLE;
          end else begin
            load_victim = 1'b1;
            state_d     = REFILL;
          end
        end
      end
      REFILL: begin
        refill_req_o = 1'b1;
        if (refill_done_i) state_d = WRITE;
      end
      WRITE: begin
        if (!flush_i) begin
          tm_req_o     = victim_q;
          tm_we_o      = 1'b1;
          tm_vbit_o    = 1'b1;
          tm_data_o    = tag_q;
          tm_addr_o    = idx_q;
          resp_valid_o = 1'b1;
          resp_way_o   = victim_q;
          bump_rr      = use_rr_q;
        end
        state_d = IDLE;
      end
      FLUSH: begin
        tm_flush_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = FLUSH;
    // Outputs must read as reset values the moment reset asserts, not a cycle later.
    if (!rstn_i) begin
      state_d        = IDLE;
      lookup_ready_o = 1'b1;
      resp_valid_o   = 1'b0;
      resp_hit_o     = 1'b0;
      resp_way_o     = '0;
      refill_req_o   = 1'b0;
      tm_req_o       = '0;
      tm_we_o        = 1'b0;
      tm_vbit_o      = 1'b0;
      tm_flush_o     = 1'b0;
      tm_data_o      = '0;
      tm_addr_o      = '0;
      load_lookup    = 1'b0;
      load_victim    = 1'b0;
      bump_rr        = 1'b0;
    end
  end

  // State and round-robin pointer; the pointer survives flushes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (bump_rr)
        rr_q <= (rr_q == way_idx_t'(ICACHE_N_WAY-1)) ? '0 : rr_q + way_idx_t'(1);
    end
  end

  // Captured lookup request and chosen victim.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx_q    <= '0;
      tag_q    <= '0;
      victim_q <= '0;
      use_rr_q <= 1'b0;
    end else begin
      if (load_lookup) begin
        idx_q <= lookup_idx_i;
        tag_q <= lookup_tag_i;
      end
      if (load_victim) begin
        victim_q <= victim_d;
        use_rr_q <= use_rr_d;
      end
    end
  end

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Scoreboard bench for the tag controller with a behavioural tag memory.
module tb_sargantana_itag_ctrl;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TW = 20;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              lookup_valid = 1'b0;
  logic              lookup_ready;
  logic [AW-1:0]     lookup_idx = '0;
  logic [TW-1:0]     lookup_tag = '0;
  logic              resp_valid, resp_hit;
  logic [N-1:0]      resp_way;
  logic              refill_req;
  logic              refill_done = 1'b0;
  logic              flush = 1'b0;
  logic [N-1:0]      tm_req;
  logic              tm_we, tm_vbit, tm_flush;
  logic [TW-1:0]     tm_data;
  logic [AW-1:0]     tm_addr;
  logic [N-1:0][TW-1:0] rd_tag;
  logic [N-1:0]      rd_v;

  sargantana_itag_ctrl #(.ICACHE_N_WAY(N), .TAG_DEPTH(D), .TAG_WIDHT(TW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_idx_i(lookup_idx), .lookup_tag_i(lookup_tag),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_way_o(resp_way),
    .refill_req_o(refill_req), .refill_done_i(refill_done), .flush_i(flush),
    .tm_req_o(tm_req), .tm_we_o(tm_we), .tm_vbit_o(tm_vbit), .tm_flush_o(tm_flush),
    .tm_data_o(tm_data), .tm_addr_o(tm_addr),
    .tm_tag_way_i(rd_tag), .tm_vbit_i(rd_v)
  );

  always #5 clk = ~clk;

  // Tag memory model with a one-cycle read and a preload port.
  bit [TW-1:0] tag_mem [N][D];
  bit          v_mem   [N][D];
  logic          pl_en = 1'b0, pl_v = 1'b0;
  int            pl_way = 0;
  logic [AW-1:0] pl_idx = '0;
  logic [TW-1:0] pl_tag = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      tag_mem[pl_way][pl_idx] <= pl_tag;
      v_mem[pl_way][pl_idx]   <= pl_v;
    end else if (tm_flush) begin
      for (int w = 0; w < N; w++)
        for (int s = 0; s < D; s++) v_mem[w][s] <= 1'b0;
    end else begin
      for (int w = 0; w < N; w++) begin
        if (tm_req[w]) begin
          if (tm_we) begin
            tag_mem[w][tm_addr] <= tm_data;
            v_mem[w][tm_addr]   <= tm_vbit;
          end else begin
            rd_tag[w] <= tag_mem[w][tm_addr];
            rd_v[w]   <= v_mem[w][tm_addr];
          end
        end
      end
    end
  end

  typedef struct {
    logic          hit;
    logic [N-1:0]  way;
    logic [TW-1:0] tag;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_rr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && resp_valid) begin
      if (sb.size() == 0) chk("unexp_resp", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_way", resp_way, e.way);
        if (!e.hit) begin
          chk("wr_we",   tm_we,   1);
          chk("wr_vbit", tm_vbit, 1);
          chk("wr_req",  tm_req,  e.way);
          chk("wr_data", tm_data, e.tag);
          chk("wr_addr", tm_addr, e.idx);
        end
      end
    end
  end

  task automatic preload(input int way, input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic v);
    @(posedge clk); #2;
    pl_en = 1'b1; pl_way = way; pl_idx = idx; pl_tag = tag; pl_v = v;
    @(posedge clk); #2;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] idx, input logic [TW-1:0] tag);
    @(posedge clk); #2;
    lookup_valid = 1'b1; lookup_idx = idx; lookup_tag = tag;
    @(negedge clk);
    chk("ready", lookup_ready, 1);
    chk("rd_req", tm_req, 4'hF);
    chk("rd_addr", tm_addr, idx);
    @(posedge clk); #2;
    lookup_valid = 1'b0;
  endtask

  task automatic wait_refill();
    int k;
    k = 0;
    while (!refill_req && k < 5) begin @(negedge clk); k++; end
    chk("refill_req_up", refill_req, 1);
  endtask

  task automatic lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input int dly);
    exp_t e;
    bit   rr_used;
    int   k;
    e.idx = idx; e.tag = tag; e.hit = 1'b0; e.way = '0;
    for (int w = N-1; w >= 0; w--)
      if (v_mem[w][idx] && tag_mem[w][idx] == tag) begin e.hit = 1'b1; e.way = '0; e.way[w] = 1'b1; end
    rr_used = 1'b0;
    if (!e.hit) begin
      rr_used = 1'b1;
      for (int w = N-1; w >= 0; w--)
        if (!v_mem[w][idx]) begin e.way = '0; e.way[w] = 1'b1; rr_used = 1'b0; end
      if (rr_used) e.way[exp_rr] = 1'b1;
    end
    sb.push_back(e);
    issue(idx, tag);
    if (e.hit) begin
      @(negedge clk);
      chk("hit_lat", resp_valid, 1);
    end else begin
      wait_refill();
      repeat (dly) begin @(negedge clk); chk("refill_hold", refill_req, 1); end
      @(posedge clk); #2 refill_done = 1'b1;
      @(posedge clk); #2 refill_done = 1'b0;
      if (rr_used) exp_rr = (exp_rr + 1) % N;
    end
    k = 0;
    while (sb.size() != 0 && k < 10) begin @(negedge clk); k++; end
    chk("resp_seen", sb.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_ready", lookup_ready, 1);
    chk("rst_resp", resp_valid, 0);
    chk("rst_refill", refill_req, 0);
    chk("rst_req", tm_req, 0);
    chk("rst_flush", tm_flush, 0);
    @(posedge clk); #2 rstn = 1'b1;

    preload(2, 5, 20'hABCDE, 1); preload(0, 5, 20'hABCDE, 0);
    preload(1, 7, 20'h12345, 1); preload(3, 7, 20'h12345, 1);
    preload(0, 3, 20'h11111, 1); preload(1, 3, 20'h22222, 1);
    for (int w = 0; w < N; w++) preload(w, 9, 20'h00900 + w, 1);

    // Stray refill_done in IDLE does nothing.
    @(posedge clk); #2 refill_done = 1'b1;
    @(negedge clk);
    chk("idle_done_ready", lookup_ready, 1);
    chk("idle_done_refill", refill_req, 0);
    @(posedge clk); #2 refill_done = 1'b0;

    lookup(5, 20'hABCDE, 0);          // hit way2
    lookup(7, 20'h12345, 0);          // multi-hit -> way1
    lookup(3, 20'h33333, 3);          // miss, victim way2
    lookup(3, 20'h33333, 0);          // now hits way2
    lookup(5, 20'hABCDF, 1);          // miss, lowest invalid way0
    for (int i = 0; i < 7; i++)       // round-robin 0..3 and wrap
      lookup(9, 20'hA0000 + i, i % 3);

    // Reset while refilling: outputs drop at once, pointer clears.
    issue(9, 20'hCCCCC);
    wait_refill();
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    chk("arst_refill", refill_req, 0);
    chk("arst_ready", lookup_ready, 1);
    chk("arst_req", tm_req, 0);
    chk("arst_resp", resp_valid, 0);
    @(posedge clk); #2 rstn = 1'b1;
    exp_rr = 0;
    lookup(9, 20'hBBBBB, 1);          // victim from rr=0

    // Flush during refill.
    issue(10, 20'h55555);
    wait_refill();
    @(posedge clk); #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    chk("fl_refill", refill_req, 0);
    chk("fl_pulse", tm_flush, 1);
    chk("fl_req", tm_req, 0);
    chk("fl_resp", resp_valid, 0);
    @(negedge clk);
    chk("fl_once", tm_flush, 0);
    chk("fl_ready", lookup_ready, 1);

    // Flush beats a simultaneous lookup.
    @(posedge clk); #2;
    flush = 1'b1; lookup_valid = 1'b1; lookup_idx = 5; lookup_tag = 20'hABCDE;
    @(negedge clk);
    chk("fl_lk_ready", lookup_ready, 0);
    chk("fl_lk_req", tm_req, 0);
    @(posedge clk); #2 flush = 1'b0; lookup_valid = 1'b0;
    @(negedge clk);
    chk("fl_lk_pulse", tm_flush, 1);
    @(negedge clk);
    chk("fl_lk_ready2", lookup_ready, 1);
    lookup(5, 20'hABCDE, 0);          // flushed -> miss into way0

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/sargantana_itag_ctrl.md
SARGANTANA_ITAG_CTRL -- requirements
Module: sargantana_itag_ctrl

Interface
REQ-001 SHALL have parameter ICACHE_N_WAY, default 4, number of ways.
REQ-002 SHALL have parameter TAG_DEPTH, default 64, sets per way.
REQ-003 SHALL have parameter TAG_ADDR_WIDHT, default $clog2(TAG_DEPTH), set-index width.
REQ-004 SHALL have parameter TAG_WIDHT, default 20, tag width.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rstn_i  in  1  asynchronous active-low reset.
REQ-006 SHALL have these lookup ports: lookup_valid_i  in  1  lookup request; lookup_ready_o  out  1  lookup accepted when valid&ready; lookup_idx_i  in  TAG_ADDR_WIDHT  set index; lookup_tag_i  in  TAG_WIDHT  tag to compare.
REQ-007 SHALL have these response ports: resp_valid_o  out  1  one-cycle result pulse; resp_hit_o  out  1  hit flag; resp_way_o  out  ICACHE_N_WAY  one-hot hit or victim way.
REQ-008 SHALL have these refill ports: refill_req_o  out  1  line fetch request, level; refill_done_i  in  1  line written to data array, pulse.
REQ-009 SHALL have flush_i  in  1  invalidate-all request, pulse.
REQ-010 SHALL have these tag-memory ports: tm_req_o  out  ICACHE_N_WAY  per-way request; tm_we_o  out  1  write; tm_vbit_o  out  1  valid bit to write; tm_flush_o  out  1  clear all valid bits; tm_data_o  out  TAG_WIDHT  tag to write; tm_addr_o  out  TAG_ADDR_WIDHT  set index; tm_tag_way_i  in  ICACHE_N_WAY x TAG_WIDHT  read tags; tm_vbit_i  in  ICACHE_N_WAY  read valid bits.

Function
REQ-011 SHALL implement FSM states IDLE, COMPARE, REFILL, WRITE, FLUSH.
REQ-012 SHALL drive lookup_ready_o=1 only in IDLE with flush_i=0.
REQ-013 SHALL, on acceptance in IDLE, register idx/tag, drive tm_req_o=all-ones, tm_we_o=0, tm_addr_o=lookup_idx_i in the same cycle, and go to COMPARE.
REQ-014 SHALL treat tm_tag_way_i/tm_vbit_i as valid in COMPARE, one cycle after the read.
REQ-015 SHALL compute hit[w] = tm_vbit_i[w] & (tm_tag_way_i[w]==registered tag); on multiple hits it SHALL report the lowest index only.
REQ-016 SHALL, on a COMPARE hit, assert resp_valid_o=1, resp_hit_o=1, resp_way_o=one-hot hit way in that cycle and return to IDLE; lookup-to-response latency is 1 cycle.
REQ-017 SHALL, on a COMPARE miss, register a victim and go to REFILL: the lowest-index way with tm_vbit_i=0, else the way one-hot of the round-robin pointer rr_q.
REQ-018 SHALL hold refill_req_o=1 throughout REFILL and go to WRITE in the cycle after refill_done_i=1.
REQ-019 SHALL, in WRITE, drive tm_req_o=victim, tm_we_o=1, tm_vbit_o=1, tm_data_o=registered tag, tm_addr_o=registered idx; assert resp_valid_o=1, resp_hit_o=0, resp_way_o=victim; then return to IDLE.
REQ-020 SHALL increment rr_q modulo ICACHE_N_WAY (ICACHE_N_WAY-1 wraps to 0) only when the WRITE used the round-robin victim.
REQ-021 SHALL, when flush_i=1 in any state, go to FLUSH next cycle, abandoning any lookup or refill with no response, with refill_req_o=0 from that cycle; flush_i wins over a simultaneous lookup.
REQ-022 SHALL, in FLUSH, drive tm_flush_o=1 for exactly one cycle with tm_req_o=0, then enter IDLE; rr_q SHALL be kept.
REQ-023 SHALL ignore refill_done_i outside REFILL.
REQ-024 SHALL drive tm_req_o=0, tm_we_o=0, and resp_valid_o=0 in all other cycles.

Reset
REQ-025 SHALL, while rstn_i=0, force state=IDLE and rr_q=0, with all outputs 0 except lookup_ready_o=1.
REQ-026 SHALL, on reset mid-refill, drop refill_req_o immediately and produce no response.

Structure
REQ-027 SHALL place the FSM state enum and the way-index type in sargantana_icache_pkg.
REQ-028 SHALL implement victim selection (invalid-first, else rr_q) as sub-module sargantana_itag_victim_sel.

Verification
REQ-029 SHALL cover: lookup idx=5, tag=0xABCDE with way2 holding 0xABCDE valid -> resp in next cycle with hit=1, way=0100.
REQ-030 SHALL cover: miss at idx=3 with ways 0,1 valid and 2 invalid -> refill_req_o high until refill_done_i; WRITE has tm_req_o=0100, tm_data_o=tag, resp hit=0, way=0100.
REQ-031 SHALL cover: four misses to one set with all ways valid from rr_q=3 -> victims 1000, 0001, 0010, 0100 (wrap).
REQ-032 SHALL cover: flush_i in REFILL -> refill_req_o=0 next cycle, tm_flush_o one pulse, no resp_valid_o, ready after FLUSH.
REQ-033 SHALL cover: flush_i and lookup_valid_i together in IDLE -> lookup not accepted, FLUSH entered.
REQ-034 SHALL cover: rstn_i low during REFILL -> all outputs at reset values asynchronously, rr_q=0.
